// File: rtl/drop_sequencer.sv
// rtl/drop_sequencer.sv - Connect 4 move controller: column scan, piece placement, turn alternation
module drop_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_game,
    input  logic        move_valid,
    input  logic [2:0]  move_col,
    output logic        move_ready,
    output logic        busy,
    output logic [83:0] board,
    output logic [1:0]  current_player,
    output logic        move_done,
    output logic        move_err,
    output logic [2:0]  placed_row,
    output logic [2:0]  placed_col,
    output logic [5:0]  move_count,
    output logic        board_full
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t      r_state;
    logic [83:0] r_board;
    logic [1:0]  r_player;
    logic [2:0]  r_col;
    logic [2:0]  r_scan_row;
    logic        r_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [2:0]  r_placed_row;
    logic [2:0]  r_placed_col;
    logic [5:0]  r_count;
    logic        r_full;

    // Bit offset of cell (scan_row, latched column); 2*(7r+c) tops out at 82.
    logic [6:0]  w_cell_idx;
    logic [7:0]  w_bit_idx;
    logic [1:0]  w_cell;

    assign w_cell_idx = ({4'd0, r_scan_row} * 7'd7) + {4'd0, r_col};
    assign w_bit_idx  = {w_cell_idx, 1'b0};
    assign w_cell     = r_board[w_bit_idx +: 2];

    always_ff @(posedge clk) begin
        if (reset || new_game) begin
            r_state      <= IDLE;
            r_board      <= '0;
            r_player     <= 2'b01;
            r_col        <= 3'd0;
            r_scan_row   <= 3'd0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_placed_row <= 3'd0;
            r_placed_col <= 3'd0;
            r_count      <= 6'd0;
            r_full       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (move_valid) begin
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (move_col <= 3'd6) begin
                            r_col      <= move_col;
                            r_scan_row <= 3'd0;
                            r_state    <= SCAN;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= REPORT;
                        end
                    end
                end
                SCAN: begin
                    if (w_cell == 2'b00) begin
                        r_board[w_bit_idx +: 2] <= r_player;
                        r_placed_row <= r_scan_row;
                        r_placed_col <= r_col;
                        r_player     <= ~r_player;
                        r_count      <= r_count + 6'd1;
                        r_full       <= (r_count == 6'd41);
                        r_done       <= 1'b1;
                        r_state      <= REPORT;
                    end else if (r_scan_row < 3'd5) begin
                        r_scan_row <= r_scan_row + 3'd1;
                    end else begin
                        // Column full (a 11 cell also counts as occupied).
                        r_err   <= 1'b1;
                        r_state <= REPORT;
                    end
                end
                REPORT: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign move_ready     = r_ready;
    assign busy           = r_busy;
    assign board          = r_board;
    assign current_player = r_player;
    assign move_done      = r_done;
    assign move_err       = r_err;
    assign placed_row     = r_placed_row;
    assign placed_col     = r_placed_col;
    assign move_count     = r_count;
    assign board_full     = r_full;

endmodule

// File: tb/tb_drop_sequencer.sv
// tb/tb_drop_sequencer.sv - directed self-checking bench for drop_sequencer
module tb_drop_sequencer;

    logic        clk;
    logic        reset;
    logic        new_game;
    logic        move_valid;
    logic [2:0]  move_col;
    logic        move_ready;
    logic        busy;
    logic [83:0] board;
    logic [1:0]  current_player;
    logic        move_done;
    logic        move_err;
    logic [2:0]  placed_row;
    logic [2:0]  placed_col;
    logic [5:0]  move_count;
    logic        board_full;

    int checks   = 0;
    int failures = 0;

    drop_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .new_game       (new_game),
        .move_valid     (move_valid),
        .move_col       (move_col),
        .move_ready     (move_ready),
        .busy           (busy),
        .board          (board),
        .current_player (current_player),
        .move_done      (move_done),
        .move_err       (move_err),
        .placed_row     (placed_row),
        .placed_col     (placed_col),
        .move_count     (move_count),
        .board_full     (board_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [83:0] got, input logic [83:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one request; return the cycle offset of the done/err pulse after the accept edge.
    task automatic do_drop(input logic [2:0] col, input bit hold,
                           output int lat, output logic done, output logic err);
        @(negedge clk);
        move_valid = 1'b1;
        move_col   = col;
        @(posedge clk);
        if (!hold) #1 move_valid = 1'b0;
        lat  = 0;
        done = 1'b0;
        err  = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (move_done || move_err) begin
                lat  = k;
                done = move_done;
                err  = move_err;
                move_valid = 1'b0;
                break;
            end
        end
        if (lat == 0) check("pulse_timeout", 84'(lat), 84'd1);
        else          check("done_err_exclusive", 84'(done & err), 84'd0);
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    logic [83:0] exp_board;
    logic [1:0]  exp_player;
    int          lat;
    logic        done;
    logic        err;
    int          seen_pulse;

    initial begin
        reset      = 1'b1;
        new_game   = 1'b0;
        move_valid = 1'b0;
        move_col   = 3'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("rst_board",  board, 84'd0);
        check("rst_player", 84'(current_player), 84'd1);
        check("rst_ready",  84'(move_ready), 84'd1);
        check("rst_busy",   84'(busy), 84'd0);
        check("rst_pulses", 84'({move_done, move_err}), 84'd0);
        check("rst_placed", 84'({placed_row, placed_col}), 84'd0);
        check("rst_count",  84'(move_count), 84'd0);
        check("rst_full",   84'(board_full), 84'd0);

        // First drop in column 3 lands at row 0.
        do_drop(3'd3, 1'b0, lat, done, err);
        check("c3_lat",    84'(lat), 84'd2);
        check("c3_done",   84'(done), 84'd1);
        check("c3_row",    84'(placed_row), 84'd0);
        check("c3_col",    84'(placed_col), 84'd3);
        check("c3_board",  board, 84'h40);
        check("c3_player", 84'(current_player), 84'd2);
        check("c3_count",  84'(move_count), 84'd1);
        @(negedge clk);
        check("c3_ready_back", 84'(move_ready), 84'd1);

        // Six alternating drops in column 0, then a column-full rejection.
        pulse_new_game();
        check("ng_board", board, 84'd0);
        exp_board  = '0;
        exp_player = 2'b01;
        for (int r = 0; r < 6; r++) begin
            do_drop(3'd0, 1'b0, lat, done, err);
            exp_board[2*(7*r) +: 2] = exp_player;
            exp_player = ~exp_player;
            check($sformatf("c0_lat_r%0d", r), 84'(lat), 84'(r + 2));
            check($sformatf("c0_row_r%0d", r), 84'(placed_row), 84'(r));
        end
        check("c0_board", board, exp_board);
        check("c0_player", 84'(current_player), 84'd1);
        do_drop(3'd0, 1'b0, lat, done, err);
        check("c0_full_lat",    84'(lat), 84'd7);
        check("c0_full_err",    84'({done, err}), 84'b01);
        check("c0_full_board",  board, exp_board);
        check("c0_full_count",  84'(move_count), 84'd6);
        check("c0_full_player", 84'(current_player), 84'd1);

        // Out-of-range column.
        do_drop(3'd7, 1'b0, lat, done, err);
        check("c7_lat",    84'(lat), 84'd1);
        check("c7_err",    84'({done, err}), 84'b01);
        check("c7_board",  board, exp_board);
        check("c7_count",  84'(move_count), 84'd6);
        check("c7_player", 84'(current_player), 84'd1);

        // move_valid held through SCAN and REPORT yields a single move.
        do_drop(3'd1, 1'b1, lat, done, err);
        check("hold_lat", 84'(lat), 84'd2);
        repeat (4) @(negedge clk);
        check("hold_count", 84'(move_count), 84'd7);
        check("hold_busy",  84'(busy), 84'd0);
        exp_board[2*1 +: 2] = 2'b01;
        check("hold_board", board, exp_board);

        // Fill the whole board column by column.
        pulse_new_game();
        exp_board  = '0;
        exp_player = 2'b01;
        for (int c = 0; c < 7; c++) begin
            for (int r = 0; r < 6; r++) begin
                do_drop(3'(c), 1'b0, lat, done, err);
                exp_board[2*(7*r + c) +: 2] = exp_player;
                exp_player = ~exp_player;
                check($sformatf("fill_lat_c%0d_r%0d", c, r), 84'(lat), 84'(r + 2));
            end
        end
        check("fill_board", board, exp_board);
        check("fill_count", 84'(move_count), 84'd42);
        check("fill_full",  84'(board_full), 84'd1);
        do_drop(3'd4, 1'b0, lat, done, err);
        check("fill_extra_lat",   84'(lat), 84'd7);
        check("fill_extra_err",   84'({done, err}), 84'b01);
        check("fill_extra_count", 84'(move_count), 84'd42);

        // new_game during SCAN of a row-3 drop aborts silently.
        pulse_new_game();
        for (int i = 0; i < 3; i++) do_drop(3'd5, 1'b0, lat, done, err);
        check("abort_setup_count", 84'(move_count), 84'd3);
        @(negedge clk);
        move_valid = 1'b1;
        move_col   = 3'd5;
        @(posedge clk);
        #1 move_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_scan", 84'(busy), 84'd1);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check("abort_board",  board, 84'd0);
        check("abort_player", 84'(current_player), 84'd1);
        check("abort_ready",  84'(move_ready), 84'd1);
        check("abort_busy",   84'(busy), 84'd0);
        check("abort_count",  84'(move_count), 84'd0);
        seen_pulse = 0;
        for (int k = 0; k < 8; k++) begin
            if (move_done || move_err) seen_pulse++;
            @(negedge clk);
        end
        check("abort_no_pulse", 84'(seen_pulse), 84'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/drop_sequencer.md
# drop_sequencer

Move controller for the Connect 4 board. Accepts one column-drop request at a time, scans that column bottom-up for the first empty cell, writes the current player's piece there and alternates turns. It owns the 6x7 board register that the cell-state checker and display logic read, and it is the only writer of that board.

## Interface
Parameters: none. Board geometry is fixed at 6 rows x 7 columns with 2-bit cells: 00 empty, 01 player 1, 10 player 2, 11 never written and treated as occupied.
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- new_game  in  1  synchronous clear, same effect as reset
- move_valid  in  1  drop request
- move_col  in  3  requested column, 0..6 (0 = leftmost)
- move_ready  out  1  high when a request can be accepted
- busy  out  1  high while a move is in progress (SCAN or REPORT)
- board  out  84  flattened board; cell (r,c) at bits [2*(7r+c)+1 : 2*(7r+c)], row 0 = bottom
- current_player  out  2  player whose turn it is: 01 or 10
- move_done  out  1  one-cycle pulse: piece placed
- move_err  out  1  one-cycle pulse: request rejected (column full or move_col > 6)
- placed_row  out  3  row of the last placed piece
- placed_col  out  3  column of the last placed piece
- move_count  out  6  pieces on the board, 0..42
- board_full  out  1  high when move_count == 42

## Operation
- Reset / new_game values: board all 00, current_player 01, move_ready 1, busy 0, move_done 0, move_err 0, placed_row 0, placed_col 0, move_count 0, board_full 0, state IDLE.
- The clear has priority over everything. It can be asserted in any state and aborts any move in progress with no done or error pulse.
- FSM states: IDLE, SCAN, REPORT.
- IDLE: move_ready = 1. On move_valid:
  - move_col <= 6: latch the column, set scan_row = 0, go to SCAN.
  - move_col = 7: go to REPORT with move_err set.
- SCAN: examine cell (scan_row, latched column) each cycle.
  - Cell is 00: write current_player into it, set placed_row/placed_col, toggle current_player, increment move_count, go to REPORT with move_done set.
  - Cell is occupied and scan_row < 5: increment scan_row and stay in SCAN.
  - Cell is occupied and scan_row = 5: go to REPORT with move_err set. Board, player and count are unchanged.
- REPORT: move_done or move_err is high for exactly this cycle; then return to IDLE.
- move_valid is ignored outside IDLE. Requests are not queued.
- move_done and move_err are never high together.
- A rejected move never changes current_player.
- board_full is informational only. Drops on a full board complete as column-full errors.
- Win detection is out of scope. It is done by a separate checker that reads board.

## Timing
- Edge E0: request accepted in IDLE.
- If the piece lands at row r: SCAN occupies r+1 cycles. The board write, player toggle and count update all take effect on the same edge. move_done is high in the following cycle, which is r+2 cycles after E0. move_ready returns the cycle after that.
- Column full: 6 SCAN cycles, then move_err in cycle 7 after E0.
- Invalid column: move_err in the cycle directly after E0.
- Back-to-back throughput: minimum 3 cycles per move (IDLE, SCAN, REPORT).
- The board output is registered. Updated cell values are visible in the move_done cycle.

## Test plan
- Reset, then drop in column 3: move_done 2 cycles after accept, placed_row=0, placed_col=3, cell (0,3)=01, current_player=10, move_count=1.
- Six alternating drops in column 0: rows 0..5 hold 01,10,01,10,01,10. A seventh drop in column 0 gives move_err 7 cycles after accept, with board, count and current_player (01) unchanged.
- move_col=7 in IDLE: move_err exactly 1 cycle later, no state change. move_valid held high during busy cycles causes no extra moves.
- Fill all 42 cells: board_full=1, move_count=42. Any further drop returns move_err.
- Assert new_game during SCAN of a 4th-row drop: next cycle the board is all 00, current_player=01, state IDLE, and no move_done or move_err pulse occurs.
